// File: rtl/csr_timer_unit.sv
// csr_timer_unit: NUM_CH LoongArch-style countdown timers (TCFG/TVAL/TICLR) with
// registered per-channel interrupts, plus a free-running stable counter for rdcnt.
module csr_timer_unit #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned TW     = 32,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic              wr_sel,
    input  logic [31:0]       wr_data,
    input  logic [31:0]       wr_mask,
    input  logic [2:0]        rd_ch,
    input  logic [1:0]        rd_sel,
    output logic [31:0]       rd_data,
    input  logic              halt,
    output logic [NUM_CH-1:0] timer_irq,
    output logic              irq_any,
    output logic [31:0]       counter_hi,
    output logic [31:0]       counter_lo
);

    logic [TW-1:0]     tcfg_q [NUM_CH];
    logic [TW-1:0]     tcfg_d [NUM_CH];
    logic [TW-1:0]     tval_q [NUM_CH];
    logic [TW-1:0]     tval_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] expire;
    logic [CNT_W-1:0]  cnt_q;
    logic [63:0]       cnt_ext;

    // Expiry: an enabled, unhalted channel whose TVAL is about to step from 1.
    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            expire[i] = tcfg_q[i][0] && !halt && (tval_q[i] == TW'(1));
        end
    end

    // Per-channel next state: countdown first, then CSR writes layered on top
    // (a TCFG write overrides TVAL, a TICLR clear loses to a coincident expiry).
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tcfg_d[i] = tcfg_q[i];
            tval_d[i] = tval_q[i];
            pend_d[i] = pend_q[i];
            if (tcfg_q[i][0] && !halt && (tval_q[i] != '0)) begin
                if (expire[i]) begin
                    pend_d[i] = 1'b1;
                    tval_d[i] = tcfg_q[i][1] ? (tcfg_q[i] & ~TW'(3)) : '0;
                end else begin
                    tval_d[i] = tval_q[i] - TW'(1);
                end
            end
            if (wr_en && (wr_ch == 3'(i))) begin
                if (!wr_sel) begin
                    tcfg_d[i] = TW'((32'(tcfg_q[i]) & ~wr_mask) | (wr_data & wr_mask));
                    tval_d[i] = tcfg_d[i] & ~TW'(3);
                end else if (wr_data[0] && wr_mask[0] && !expire[i]) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
    end

    // Timer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tcfg_q[i] <= '0;
                tval_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                tcfg_q[i] <= tcfg_d[i];
                tval_q[i] <= tval_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Stable counter: free-running, ignores halt, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Combinational CSR read mux; unknown channels and the reserved selector read 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == 3'(i)) begin
                case (rd_sel)
                    2'd0:    rd_data = 32'(tcfg_q[i]);
                    2'd1:    rd_data = 32'(tval_q[i]);
                    default: rd_data = '0;
                endcase
            end
        end
    end

    assign cnt_ext    = 64'(cnt_q);
    assign counter_hi = cnt_ext[63:32];
    assign counter_lo = cnt_ext[31:0];
    assign timer_irq  = pend_q;
    assign irq_any    = |pend_q;

endmodule

// File: tb/tb_csr_timer_unit.sv
// Self-checking bench for csr_timer_unit: a vector table applied through a
// scoreboard queue, plus hand-written halt, reset and narrow-width sequences.
module tb_csr_timer_unit;

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_ch = '0;
    logic        wr_sel = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] wr_mask = '0;
    logic [2:0]  rd_ch = '0;
    logic [1:0]  rd_sel = '0;
    logic        halt = 1'b0;
    logic [31:0] rd_data, counter_hi, counter_lo;
    logic [1:0]  timer_irq;
    logic        irq_any;
    logic [31:0] rd_data8, counter_hi8, counter_lo8;
    logic [1:0]  timer_irq8;
    logic        irq_any8;

    csr_timer_unit dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_data(rd_data), .halt(halt), .timer_irq(timer_irq), .irq_any(irq_any),
        .counter_hi(counter_hi), .counter_lo(counter_lo)
    );

    csr_timer_unit #(.NUM_CH(2), .TW(8), .CNT_W(40)) dut8 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_data(rd_data8), .halt(halt), .timer_irq(timer_irq8), .irq_any(irq_any8),
        .counter_hi(counter_hi8), .counter_lo(counter_lo8)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        we;
        bit [2:0]  wch;
        bit        wsel;
        bit [31:0] wd;
        bit [31:0] wm;
        bit [2:0]  rch;
        bit [1:0]  rsel;
        bit        h;
        int        cyc;
        bit [31:0] erd;
        bit [1:0]  eirq;
    } vec_t;

    typedef struct {
        int        id;
        bit [31:0] erd;
        bit [1:0]  eirq;
        bit [63:0] ecnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;

    function automatic vec_t mk(bit we, bit [2:0] wch, bit wsel, bit [31:0] wd, bit [31:0] wm,
                                bit [2:0] rch, bit [1:0] rsel, bit h, int cyc,
                                bit [31:0] erd, bit [1:0] eirq);
        vec_t v;
        v.we = we; v.wch = wch; v.wsel = wsel; v.wd = wd; v.wm = wm;
        v.rch = rch; v.rsel = rsel; v.h = h; v.cyc = cyc; v.erd = erd; v.eirq = eirq;
        return v;
    endfunction

    task automatic chk(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h, required %0h", name, id, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        halt  = 1'b0;
        ncyc  = 0;
    endtask

    task automatic expect_out(input int id, input bit [31:0] erd, input bit [1:0] eirq);
        exp_t e;
        e.id = id; e.erd = erd; e.eirq = eirq; e.ecnt = 64'(ncyc);
        sb.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with the current DUT outputs.
    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", -1, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            e.ecnt = 64'(ncyc);
            chk("rd_data", e.id, 64'(rd_data), 64'(e.erd));
            chk("timer_irq", e.id, 64'(timer_irq), 64'(e.eirq));
            chk("irq_any", e.id, 64'(irq_any), 64'(e.eirq != 2'b00));
            chk("counter", e.id, {counter_hi, counter_lo}, e.ecnt);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        wr_en = v.we; wr_ch = v.wch; wr_sel = v.wsel; wr_data = v.wd; wr_mask = v.wm;
        rd_ch = v.rch; rd_sel = v.rsel; halt = v.h;
        expect_out(id, v.erd, v.eirq);
        for (int c = 0; c < v.cyc; c++) tick();
        check_out();
    endtask

    initial begin
        int n;
        // Channel 0 one-shot (load 8), csrxchg En toggle, out-of-range accesses.
        tbl.push_back(mk(1, 0, 0, 32'h9, ALL, 0, 0, 0, 1, 32'h9, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'd7, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 6, 32'd1, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'd0, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3, 32'd0, 2'b01));
        tbl.push_back(mk(1, 0, 1, 32'h1, ALL, 0, 2, 0, 1, 32'd0, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 20, 32'd0, 2'b00));
        tbl.push_back(mk(1, 0, 0, 32'h0, 32'h1, 0, 0, 0, 1, 32'h8, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5, 32'd8, 2'b00));
        tbl.push_back(mk(1, 0, 0, 32'h1, 32'h1, 0, 1, 0, 1, 32'd8, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8, 32'd0, 2'b01));
        tbl.push_back(mk(1, 0, 1, 32'h1, 32'h0, 0, 2, 0, 1, 32'd0, 2'b01));
        tbl.push_back(mk(1, 7, 0, 32'hFF, ALL, 7, 0, 0, 1, 32'd0, 2'b01));
        tbl.push_back(mk(1, 7, 1, 32'h1, ALL, 0, 0, 0, 1, 32'h9, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 1, 32'd0, 2'b01));
        tbl.push_back(mk(1, 0, 1, 32'h1, ALL, 0, 1, 0, 1, 32'd0, 2'b00));
        // Channel 1 periodic (load 16): clear mid-period, clear at expiry, write at expiry.
        tbl.push_back(mk(1, 1, 0, 32'h13, ALL, 1, 0, 0, 1, 32'h13, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 15, 32'd1, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'd16, 2'b10));
        tbl.push_back(mk(1, 1, 1, 32'h1, ALL, 1, 1, 0, 1, 32'd15, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 14, 32'd1, 2'b00));
        tbl.push_back(mk(1, 1, 1, 32'h1, ALL, 1, 1, 0, 1, 32'd16, 2'b10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 15, 32'd1, 2'b10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'd16, 2'b10));
        tbl.push_back(mk(1, 1, 1, 32'h1, ALL, 1, 1, 0, 1, 32'd15, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 14, 32'd1, 2'b00));
        tbl.push_back(mk(1, 1, 0, 32'hB, ALL, 1, 1, 0, 1, 32'd8, 2'b10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hB, 2'b10));
        tbl.push_back(mk(1, 1, 0, 32'h0, ALL, 1, 1, 0, 1, 32'd0, 2'b10));
        tbl.push_back(mk(1, 1, 1, 32'h1, ALL, 1, 0, 0, 1, 32'd0, 2'b00));

        // Reset state, then 20 idle cycles.
        @(posedge clk);
        do_reset();
        expect_out(100, 32'd0, 2'b00);
        check_out();
        for (int c = 0; c < 20; c++) tick();
        chk("idle_counter_lo", 101, 64'(counter_lo), 64'd20);
        expect_out(101, 32'd0, 2'b00);
        check_out();

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Halt for 5 cycles mid-count delays the load-8 expiry to 13 edges.
        apply(mk(1, 0, 0, 32'h9, ALL, 0, 1, 0, 1, 32'd8, 2'b00), 200);
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 3, 32'd5, 2'b00), 201);
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 5, 32'd5, 2'b00), 202);
        halt = 1'b0;
        n = 8;
        while (timer_irq[0] !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("halt_expiry_edges", 203, 64'(n), 64'd13);
        expect_out(204, 32'd0, 2'b01);
        check_out();

        // Reset mid-countdown clears the channel; no counting until a new write.
        apply(mk(1, 0, 1, 32'h1, ALL, 0, 1, 0, 1, 32'd0, 2'b00), 300);
        apply(mk(1, 0, 0, 32'h9, ALL, 0, 1, 0, 3, 32'd6, 2'b00), 301);
        do_reset();
        expect_out(302, 32'd0, 2'b00);
        check_out();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 32'd0, 2'b00), 303);

        // Narrow build: TW=8 truncation and load value, counter_hi stays zero.
        wr_en = 1'b1; wr_ch = 3'd0; wr_sel = 1'b0; wr_data = 32'hFFFF_FFFD; wr_mask = ALL;
        rd_ch = 3'd0; rd_sel = 2'd0;
        tick();
        chk("tw8_tcfg", 400, 64'(rd_data8), 64'hFD);
        rd_sel = 2'd1;
        #1;
        chk("tw8_tval", 401, 64'(rd_data8), 64'hFC);
        chk("tw8_counter_lo", 402, 64'(counter_lo8), 64'(ncyc));
        chk("tw8_counter_hi", 403, 64'(counter_hi8), 64'd0);
        chk("tw8_irq", 404, 64'(timer_irq8), 64'd0);

        if (sb.size() != 0) chk("scoreboard_leftover", 500, 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_timer_unit.md
# csr_timer_unit

Parametrised multi-channel timer and stable-counter block for the CSR file of the LoongArch core. It provides NUM_CH independent countdown timers with LoongArch TCFG/TVAL/TICLR semantics, one registered interrupt line per channel, and a free-running stable counter for rdcnt. Compared with the single hard-wired timer it replaces, it adds:
- configurable channel count and timer width;
- a debug `halt` freeze;
- a defined outcome when clear and expiry coincide: no interrupt is lost.

## Interface
Parameters:
- NUM_CH, default 2: number of timer channels (1..8).
- TW, default 32: timer width in bits (4..32); TCFG/TVAL hold TW bits.
- CNT_W, default 64: stable counter width (33..64).

Ports:
- clk  in  1  clock; reset is synchronous, active-high (reset, in, 1).
- reset  in  1  synchronous active-high reset.
- wr_en  in  1  CSR write strobe.
- wr_ch  in  3  target channel.
- wr_sel  in  1  0 = TCFG, 1 = TICLR.
- wr_data  in  32  write data.
- wr_mask  in  32  bit write mask (csrxchg); all-ones for csrwr.
- rd_ch  in  3  read channel.
- rd_sel  in  2  0 = TCFG, 1 = TVAL, 2 = TICLR, 3 = reserved.
- rd_data  out  32  combinational read data.
- halt  in  1  freezes all TVAL decrements while 1.
- timer_irq  out  NUM_CH  per-channel pending interrupt (ESTAT.TI source).
- irq_any  out  1  OR of timer_irq.
- counter_hi  out  32  stable counter [CNT_W-1:32], zero-extended.
- counter_lo  out  32  stable counter [31:0].

## Operation
TCFG layout per channel:
- bit0 En.
- bit1 Periodic.
- [TW-1:2] InitVal.
- Bits [31:TW] are not stored and read as 0.

TCFG write:
- New value is (old & ~mask) | (data & mask), truncated to TW bits.
- On the same edge, TVAL loads {newTCFG[TW-1:2], 2'b00}, whether or not En is set.

Countdown (per channel, En=1 and halt=0):
- TVAL != 0: TVAL <= TVAL-1.
- TVAL == 1 (expiry): pending <= 1.
  - Periodic=1: TVAL reloads {InitVal, 00} instead of reaching 0.
  - Periodic=0: TVAL becomes 0 and holds. En stays 1, and there are no further expiries.
- TVAL == 0: TVAL holds at 0. No wrap and no interrupt.
- En=0 or halt=1: TVAL holds and pending holds.

TICLR write:
- If (data & mask) bit0 = 1, pending clears. No other TICLR state is stored.
- TICLR reads return 0.

Simultaneous events on one channel, in priority order:
- Expiry together with a TICLR clear: pending = 1. Expiry wins.
- Expiry together with a TCFG write: pending = 1, and TVAL takes the written load value.
- Reset overrides everything.

Out-of-range cases:
- Writes to wr_ch >= NUM_CH are ignored.
- Reads from rd_ch >= NUM_CH, or with rd_sel = 3, return 0.

Stable counter:
- Increments by 1 every cycle after reset. It is not affected by halt.
- Wraps modulo 2^CNT_W.

Reset values:
- All TCFG = 0, all TVAL = 0, all pending = 0, counter = 0.
- Hence timer_irq = 0, irq_any = 0, counter_hi = 0, counter_lo = 0.
- rd_data follows the reset register state.

## Timing
- Writes take effect at the sampling edge. rd_data reflects the new value in the following cycle.
- Expiry latency: a TCFG write with En=1 and InitVal field = N (load value L = 4N) sampled at edge E0 gives TVAL = L after E0. TVAL = 1 after E(L-1). timer_irq rises after E(L).
- Periodic period: exactly L cycles between rising expiries.
- timer_irq is a direct register output, with no combinational path from inputs. irq_any is a combinational OR of registers.
- Each cycle of halt=1 delays expiry by exactly one cycle.
- counter_lo/counter_hi are registered. Reading both in the same cycle yields a coherent 64-bit snapshot.
- Reset mid-countdown clears the channel on that edge. Counting resumes only after a new TCFG write.

## Test plan
- Reset, then idle for 20 cycles → timer_irq = 0, and counter_lo = 20 at the 20th cycle after reset deassertion (±0).
- Ch0 TCFG = 0x9 (En=1, Periodic=0, load 8) → irq0 rises exactly 8 edges after the write. TVAL reads 0 and holds. TICLR bit0 clears irq0, and it never re-asserts.
- Ch1 TCFG = 0x13 (periodic, load 16) → expiries 16 cycles apart. TICLR within a period drops irq1 until the next expiry. TICLR in the exact expiry cycle leaves irq1 = 1.
- Ch0 load 8 with halt held for 5 cycles mid-count → irq0 at 13 edges. Counter unaffected (+13).
- csrxchg-style TCFG write with mask 0x1 toggles only En, and TVAL reloads from the retained InitVal. A write to channel 7 with NUM_CH = 2 leaves all state unchanged and reads 0.
- TW = 8, CNT_W = 40 build: TCFG = 0xFFFFFFFD reads 0xFD. TVAL loads 0xFC. counter_hi increments when bit 31 carries.
